bus_arb_mux: RTL
================

Name: bus_arb_mux

Overview:
- Parametrised, registered successor to the datapath bus multiplexer. It connects NSRC sources (registers, HI/LO, Z, PC, MDR, InPort, C_sign_extended, ...) to a single WIDTH-bit bus.
- Each source raises a request instead of driving a raw select. The block arbitrates between requests, locks ownership for a bounded number of cycles, and registers the winner's data onto the bus.
- It sits between the register file / special registers and every bus consumer (ALU Y, MAR, MDR, ...), and replaces the purely combinational encoder+mux.

Parameters:
- WIDTH, 32, bus and per-source data width.
- NSRC, 25, number of bus sources (2..32).
- SELW, $clog2(NSRC), width of the encoded select output.
- MAX_HOLD, 4, maximum consecutive cycles one source may own the bus while other requests are pending (1..255).
- HOLD_LAST, 1: 1 = bus_out holds its last value when idle; 0 = bus_out drives zero when idle.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- src_data  in  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_req  in  NSRC  per-source bus request (the "Rxout" strobes).
- src_grant  out  NSRC  one-hot registered grant; all zero when idle.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high when bus_out carries data from a granted source.
- bus_sel  out  SELW  index of the granted source; 0 when idle.
- conflict  out  1  one-cycle pulse: more than one request was sampled in the previous cycle.

Behaviour:
- Reset: clear sampled high at a rising edge sets src_grant=0, bus_out=0, bus_valid=0, bus_sel=0, conflict=0, hold counter=0, round-robin pointer=0, state=IDLE. Clear wins over all other activity, including mid-ownership.
- States:
  - IDLE: no owner.
  - OWN: owner registered in src_grant.
- Latency: requests and data sampled at edge k appear on src_grant, bus_sel, bus_out and bus_valid after edge k. Latency is one cycle.
- IDLE, no request: stay IDLE. bus_valid=0; bus_out = previous value (HOLD_LAST=1) or 0 (HOLD_LAST=0).
- IDLE, any request: arbitrate, grant the winner, go to OWN, hold counter=1, bus_out=src_data[winner].
- OWN, owner request still high, and (counter<MAX_HOLD or no other request): keep owner. bus_out=src_data[owner] sampled each cycle. Counter increments and saturates at MAX_HOLD.
- OWN, owner request still high, counter==MAX_HOLD, another request pending: forced handover. Arbitrate among requests with the owner masked; new owner takes effect on the same edge; counter=1.
- OWN, owner request drops: if another request is present, arbitrate (owner not masked) and grant on the same edge with no idle bubble, counter=1. Otherwise go to IDLE with bus_valid=0.
- Arbitration (default): fixed priority, lowest index wins.
- src_grant is always one-hot or zero. bus_sel is the binary encoding of src_grant.
- conflict: registered popcount(src_req)>1 of the previous cycle. Asserts in any state; it is a diagnostic only.
- src_req bits at index >= NSRC do not exist. Packed data beyond NSRC*WIDTH is not accessed.
- No combinational path from src_req or src_data to any output.

Optional Feature:
- Macro BUS_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (rr_ptr) and wraps modulo NSRC. On every grant, rr_ptr = winner+1, wrapping NSRC-1 -> 0. The masked-owner rule still applies at MAX_HOLD expiry.
- Undefined: fixed lowest-index priority as above. The rr_ptr register is absent.

Decomposition:
- Shared package bus_pkg holds:
  - default WIDTH and NSRC constants;
  - named source indices (SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN);
  - the state enum {ST_IDLE, ST_OWN}.
- One sub-module: bus_arb_pick. It is combinational: takes a request vector, a mask and a start pointer, and returns a one-hot winner plus a found flag. The fixed-priority mode uses pointer=0.

Test Plan (NSRC=25, WIDTH=32, MAX_HOLD=4):
- Reset mid-ownership: grant src 3, then assert clear for one edge -> next cycle src_grant=0, bus_out=0, bus_valid=0, bus_sel=0; src 3 still requesting -> regranted one cycle after clear drops.
- Single source: src_data[0]=9007, req[0] for 1 cycle -> one cycle later bus_out=9007, bus_sel=0, bus_valid=1. Then req[1] with data 69696969 -> bus_out=69696969, bus_sel=1. Then idle -> bus_valid=0, bus_out stays 69696969 (HOLD_LAST=1), or 0 with HOLD_LAST=0.
- Contention, fixed priority: req[5] and req[2] together, held -> conflict pulses the next cycle. src 2 owns 4 cycles, then src 5 owns 4 cycles, then back to src 2. Grant is never zero between owners.
- Round robin (BUS_ARB_RR_EN): req[24] and req[0] held -> src 0 owns, then 24, then wraps to 0 every 4 cycles. The handover after 24 -> rr_ptr wraps to 0.
- Data tracking: src 7 owns while its data changes 1,2,3 on consecutive cycles -> bus_out follows 1,2,3 delayed by one cycle.
- Owner drop with waiter: src 4 owns, req[9] asserted, req[4] drops at counter=2 -> grant moves to src 9 on the next edge with no bubble.

Source files
------------

// File: rtl/bus_arb_mux_pkg.sv
// Shared constants, source indices and state type for the bus arbiter.
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 25;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_t;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Request/grant bundle between bus sources and the registered bus arbiter.
interface bus_arb_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int NSRC  = BUS_NSRC,
  parameter int SELW  = $clog2(NSRC)
);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_req;
  logic [NSRC-1:0]       src_grant;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_sel;
  logic                  conflict;

  modport master (
    output src_data,
    output src_req,
    input  src_grant,
    input  bus_out,
    input  bus_valid,
    input  bus_sel,
    input  conflict
  );

  modport slave (
    input  src_data,
    input  src_req,
    output src_grant,
    output bus_out,
    output bus_valid,
    output bus_sel,
    output conflict
  );

endinterface

// File: rtl/bus_arb_mux_pick.sv
// Combinational winner search: first unmasked request at or after ptr,
// wrapping modulo NSRC.
module bus_arb_pick #(
  parameter int NSRC = 25,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] mask,
  input  logic [SELW-1:0] ptr,
  output logic [NSRC-1:0] win,
  output logic            found
);

  int              j;
  logic [SELW-1:0] jj;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NSRC; i++) begin
      j = int'(ptr) + i;
      if (j >= NSRC) j = j - NSRC;
      jj = SELW'(j);
      if (!found && req[jj] && !mask[jj]) begin
        win[jj] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered bus arbiter/mux with bounded ownership.
// Define BUS_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int NSRC      = BUS_NSRC,
  parameter int SELW      = $clog2(NSRC),
  parameter int MAX_HOLD  = 4,
  parameter int HOLD_LAST = 1
) (
  input logic        clock,
  input logic        clear,
  bus_arb_mux_if.slave bus
);

  state_t            state_q, state_n;
  logic [NSRC-1:0]   grant_q, grant_n;
  logic [NSRC-1:0]   mask, win;
  logic              found, take;
  logic [7:0]        cnt_q, cnt_n;
  logic [WIDTH-1:0]  data_q, data_n;
  logic [SELW-1:0]   sel_q, sel_n, ptr;
  logic              valid_q, valid_n;
  logic              conflict_q;
  logic              owner_req, others, expired;

  assign owner_req = |(bus.src_req & grant_q);
  assign others    = |(bus.src_req & ~grant_q);
  assign expired   = (cnt_q == 8'(MAX_HOLD));
  // Mask the owner only when its hold has run out and someone is waiting
  assign mask = (owner_req && expired && others) ? grant_q : '0;

`ifdef BUS_ARB_RR_EN
  logic [SELW-1:0] rr_q, rr_n;

  assign ptr = rr_q;

  always_comb begin
    rr_n = rr_q;
    if (take)
      rr_n = (sel_n == SELW'(NSRC - 1)) ? '0 : sel_n + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) rr_q <= '0;
    else       rr_q <= rr_n;
  end
`else
  assign ptr = '0;
`endif

  bus_arb_pick #(
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_pick (
    .req   (bus.src_req),
    .mask  (mask),
    .ptr   (ptr),
    .win   (win),
    .found (found)
  );

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    cnt_n   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_n = ST_OWN;
          grant_n = win;
          cnt_n   = 8'd1;
        end
      end
      ST_OWN: begin
        if (owner_req && !(expired && others)) begin
          if (!expired) cnt_n = cnt_q + 8'd1;
        end else if (found) begin
          take    = 1'b1;
          grant_n = win;
          cnt_n   = 8'd1;
        end else begin
          state_n = ST_IDLE;
          grant_n = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    data_n  = '0;
    sel_n   = '0;
    valid_n = |grant_n;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_n[i]) begin
        data_n = data_n | bus.src_data[i*WIDTH +: WIDTH];
        sel_n  = sel_n | SELW'(i);
      end
    end
    if (!valid_n)
      data_n = (HOLD_LAST != 0) ? data_q : '0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      grant_q    <= grant_n;
      cnt_q      <= cnt_n;
      data_q     <= data_n;
      sel_q      <= sel_n;
      valid_q    <= valid_n;
      conflict_q <= ($countones(bus.src_req) > 1);
    end
  end

  assign bus.src_grant = grant_q;
  assign bus.bus_out   = data_q;
  assign bus.bus_valid = valid_q;
  assign bus.bus_sel   = sel_q;
  assign bus.conflict  = conflict_q;

endmodule
